// File: rtl/weight_link_pkg.sv
// Shared definitions for the weight-load link: frame sizing, lane width and
// the producer control states.
package weight_link_pkg;

  localparam int unsigned LaneW = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush,
    StDone
  } link_state_e;

  // Words per frame: WHH section followed by WIH section.
  function automatic int unsigned frame_len(input int unsigned input_size,
                                            input int unsigned hidden_size);
    return hidden_size * hidden_size * 5 / 2 + input_size * hidden_size * 2;
  endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Small synchronous FIFO holding memory read returns until the sink can take them.
module weight_skid_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 16
) (
  input  logic                   clk_200m,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int unsigned PtrW = $clog2(Depth);

  if ((1 << PtrW) != Depth) begin : g_bad_depth
    $error("weight_skid_fifo Depth must be a power of 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_200m) begin
    if (do_push && !clr) mem_q[wptr_q] <= wdata;
  end

  // The producer's credit rule must keep this from ever firing.
  assert property (@(posedge clk_200m) disable iff (rst) !(push && !clr && full && !do_pop))
    else $error("weight_skid_fifo overflow");

endmodule

// File: rtl/weight_stream_src.sv
// Producer end of the weight-load link: reads one frame from word memory and streams it
// into the 4-lane weight FIFO sink, with credit-limited reads and fifo_ready back-pressure.
module weight_stream_src
  import weight_link_pkg::*;
#(
  parameter int unsigned INPUT_SIZE      = 96,
  parameter int unsigned HIDDEN_SIZE     = 512,
  parameter int unsigned FRAME_LEN       = frame_len(INPUT_SIZE, HIDDEN_SIZE),
  parameter int unsigned BASE_ADDR       = 0,
  parameter int unsigned ADDR_W          = 24,
  parameter int unsigned SKID_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk_200m,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  input  logic              fifo_ready,
  output logic              wr_fifo_data_valid,
  output logic [15:0]       wr_fifo_data,
  output logic [LaneW-1:0]  lane,
  output logic              busy,
  output logic              frame_done
);
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OccW = $clog2(SKID_DEPTH) + 1;
  localparam int unsigned SumW = OccW + 1;

  if (FRAME_LEN % 4 != 0) begin : g_bad_frame_len
    $error("FRAME_LEN must be a multiple of 4");
  end
  if (SKID_DEPTH < MAX_OUTSTANDING) begin : g_bad_skid
    $error("SKID_DEPTH must be >= MAX_OUTSTANDING");
  end

  link_state_e      state_q, state_d;
  logic [CntW-1:0]  issue_cnt_q, issue_cnt_d, send_cnt_q, send_cnt_d;
  logic [OutW-1:0]  outstanding_q, outstanding_d;
  logic             req_pend_q, req_pend_d;
  logic             valid_q, valid_d;
  logic [15:0]      data_q, data_d;
  logic [LaneW-1:0] lane_q, lane_d;

  logic             issue_ok, issue, push, pop, skid_clr, skid_empty, rvalid_dec;
  logic [15:0]      skid_rdata;
  logic [OccW-1:0]  occ;

  weight_skid_fifo #(
    .Depth (SKID_DEPTH),
    .Width (16)
  ) u_skid (
    .clk_200m (clk_200m),
    .rst      (rst),
    .clr      (skid_clr),
    .push     (push),
    .pop      (pop),
    .wdata    (mem_rdata),
    .rdata    (skid_rdata),
    .empty    (skid_empty),
    .count    (occ)
  );

  // Reserving skid space for every read in flight is what makes overflow impossible.
  assign issue_ok = (issue_cnt_q < CntW'(FRAME_LEN))
                  & ((SumW'(outstanding_q) + SumW'(occ)) < SumW'(SKID_DEPTH))
                  & (outstanding_q < OutW'(MAX_OUTSTANDING))
                  & fifo_ready;
  assign issue      = mem_req & mem_gnt;
  assign rvalid_dec = mem_rvalid & (outstanding_q != '0);
  assign mem_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(issue_cnt_q);

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start && !abort) state_d = StStream;
      StStream: begin
        if (abort)                                 state_d = StFlush;
        else if (send_cnt_q == CntW'(FRAME_LEN))   state_d = StDone;
      end
      StFlush:  if (outstanding_d == '0) state_d = StIdle;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    skid_clr   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StStream: begin
        // A presented request is held regardless of fifo_ready; abort drops it.
        mem_req = ~abort & (req_pend_q | issue_ok);
        pop     = ~abort & ~skid_empty & fifo_ready;
        push    = mem_rvalid;
      end
      StFlush:  skid_clr = 1'b1;
      StDone:   frame_done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  always_comb begin
    issue_cnt_d   = issue_cnt_q;
    send_cnt_d    = send_cnt_q;
    if (state_q == StIdle && start && !abort) begin
      issue_cnt_d = '0;
      send_cnt_d  = '0;
    end else begin
      if (issue) issue_cnt_d = issue_cnt_q + CntW'(1);
      if (pop)   send_cnt_d  = send_cnt_q + CntW'(1);
    end
    outstanding_d = outstanding_q + OutW'(issue) - OutW'(rvalid_dec);
    req_pend_d    = mem_req & ~mem_gnt;
    valid_d       = pop;
    data_d        = pop ? skid_rdata : data_q;
    lane_d        = pop ? send_cnt_q[LaneW-1:0] : lane_q;
  end

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      issue_cnt_q   <= '0;
      send_cnt_q    <= '0;
      outstanding_q <= '0;
      req_pend_q    <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      lane_q        <= '0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      send_cnt_q    <= send_cnt_d;
      outstanding_q <= outstanding_d;
      req_pend_q    <= req_pend_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      lane_q        <= lane_d;
    end
  end

  assign wr_fifo_data_valid = valid_q;
  assign wr_fifo_data       = data_q;
  assign lane               = lane_q;

endmodule

// File: tb/tb_weight_stream_src.sv
// Bench for weight_stream_src: in-order memory model with random grant/latency, a word
// scoreboard filled at start, and a 4-lane sink model.
module tb_weight_stream_src;
  localparam int unsigned FrameLen  = 224;
  localparam int unsigned MaxOut    = 4;
  localparam int unsigned LaneWords = FrameLen / 4;

  logic        clk_200m = 1'b0;
  logic        rst, start, abort, mem_req, mem_gnt, mem_rvalid, fifo_ready;
  logic        wr_fifo_data_valid, busy, frame_done;
  logic [23:0] mem_addr;
  logic [15:0] mem_rdata, wr_fifo_data;
  logic [1:0]  lane;

  always #5 clk_200m = ~clk_200m;

  weight_stream_src #(
    .INPUT_SIZE  (4),
    .HIDDEN_SIZE (8)
  ) dut (
    .clk_200m           (clk_200m),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_gnt            (mem_gnt),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .fifo_ready         (fifo_ready),
    .wr_fifo_data_valid (wr_fifo_data_valid),
    .wr_fifo_data       (wr_fifo_data),
    .lane               (lane),
    .busy               (busy),
    .frame_done         (frame_done)
  );

  typedef struct {
    int unsigned due;
    logic [15:0] data;
  } rd_t;

  typedef struct {
    int unsigned gnt_pct;
    int unsigned lat_min;
    int unsigned lat_max;
    int          bp_word;
    int unsigned bp_len;
    int unsigned exp_words;
  } vec_t;

  rd_t         rq[$];
  int unsigned exp_q[$];
  int unsigned n_chk, n_fail, cyc, last_due;
  int unsigned gnt_pct, lat_min, lat_max, bp_len, bp_left;
  int          bp_trig;
  int unsigned exp_issue, words_rx, last_valid_cyc, done_cyc, done_cnt;
  int unsigned lane_cnt[4];
  logic        start_nxt, abort_nxt, ready_prev, req_prev, gnt_prev, no_valid;
  logic [23:0] addr_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_mem_req"}, 32'(mem_req), 0);
    check({name, "_mem_addr"}, 32'(mem_addr), 0);
    check({name, "_valid"}, 32'(wr_fifo_data_valid), 0);
    check({name, "_data"}, 32'(wr_fifo_data), 0);
    check({name, "_lane"}, 32'(lane), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic observe();
    if (mem_req && mem_gnt) begin
      int unsigned due;
      rd_t r;
      due = cyc + $urandom_range(lat_max, lat_min);
      check("issue_addr", 32'(mem_addr), exp_issue);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due  = due;
      r.data = mem_addr[15:0] ^ 16'hA5A5;
      rq.push_back(r);
      exp_issue++;
    end
    check("outstanding_le_max", 32'(rq.size() <= int'(MaxOut)), 1);
    if (req_prev && !gnt_prev && !abort) begin
      check("req_hold", 32'(mem_req), 1);
      check("addr_hold", 32'(mem_addr), 32'(addr_prev));
    end
    if (wr_fifo_data_valid) begin
      logic [15:0] idx;
      words_rx++;
      last_valid_cyc = cyc;
      check("valid_while_ready_low", 32'(ready_prev), 1);
      check("valid_after_abort", 32'(no_valid), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(wr_fifo_data), 32'hFFFF_FFFF);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        check("word_data", 32'(wr_fifo_data), 32'(16'(e) ^ 16'hA5A5));
        check("word_lane", 32'(lane), e % 4);
      end
      // Sink model: lane j must see words 4n+j in order.
      idx = wr_fifo_data ^ 16'hA5A5;
      check("sink_lane_word", 32'(idx), lane_cnt[lane] * 4 + 32'(lane));
      lane_cnt[lane]++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    req_prev   = mem_req;
    gnt_prev   = mem_gnt;
    addr_prev  = mem_addr;
    ready_prev = fifo_ready;
  endtask

  task automatic step();
    @(negedge clk_200m);
    cyc++;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].data;
      rq.delete(0);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0;
    end
    mem_gnt = ($urandom_range(99) < gnt_pct);
    if (bp_trig >= 0 && int'(words_rx) >= bp_trig) begin
      bp_left = bp_len;
      bp_trig = -1;
    end
    fifo_ready = (bp_left == 0);
    if (bp_left != 0) bp_left--;
    start     = start_nxt;
    abort     = abort_nxt;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    #1;
    observe();
  endtask

  task automatic start_frame();
    exp_q.delete();
    for (int i = 0; i < int'(FrameLen); i++) exp_q.push_back(i);
    for (int j = 0; j < 4; j++) lane_cnt[j] = 0;
    exp_issue = 0;
    words_rx  = 0;
    done_cnt  = 0;
    no_valid  = 1'b0;
    last_due  = cyc;
    start_nxt = 1'b1;
  endtask

  task automatic wait_words(input int unsigned n);
    int unsigned guard = 0;
    while (words_rx < n && guard < 3000) begin
      step();
      guard++;
    end
    check("wait_words_reached", 32'(words_rx >= n), 1);
  endtask

  task automatic run_frame(input string name, input int unsigned exp_words);
    int unsigned guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      step();
      guard++;
    end
    check({name, "_done_seen"}, done_cnt, 1);
    check({name, "_words"}, words_rx, exp_words);
    check({name, "_leftover"}, 32'(exp_q.size()), 0);
    check({name, "_done_timing"}, done_cyc, last_valid_cyc + 1);
    for (int j = 0; j < 4; j++) check({name, "_lane_count"}, lane_cnt[j], LaneWords);
    step();
    check({name, "_busy_low"}, 32'(busy), 0);
    check({name, "_done_pulse"}, done_cnt, 1);
  endtask

  task automatic abort_seq(input string name, input int unsigned at_word, input logic with_start);
    int unsigned guard = 0;
    start_frame();
    wait_words(at_word);
    abort_nxt = 1'b1;
    start_nxt = with_start;
    step();
    no_valid = 1'b1;
    step();
    check({name, "_flush_busy"}, 32'(busy), 1);
    while (busy && guard < 200) begin
      step();
      guard++;
    end
    check({name, "_flush_exit"}, 32'(busy), 0);
    check({name, "_reads_absorbed"}, 32'(rq.size()), 0);
    repeat (4) step();
    check({name, "_stays_idle"}, 32'(busy), 0);
    check({name, "_no_done"}, done_cnt, 0);
  endtask

  initial begin
    vec_t vecs[3];
    n_chk = 0; n_fail = 0; cyc = 0; last_due = 0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; bp_trig = -1; bp_len = 0; bp_left = 0;
    exp_issue = 0; words_rx = 0; last_valid_cyc = 0; done_cyc = 0; done_cnt = 0;
    start_nxt = 1'b0; abort_nxt = 1'b0; ready_prev = 1'b1; req_prev = 1'b0;
    gnt_prev = 1'b0; no_valid = 1'b0; addr_prev = '0;
    for (int j = 0; j < 4; j++) lane_cnt[j] = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 16'h0; fifo_ready = 1'b1;
    #1;
    check_idle_outputs("reset");
    @(negedge clk_200m);
    rst = 1'b0;

    // Streaming, back-pressure at word 50 for 20 cycles, random memory stalls.
    vecs[0] = '{100, 1, 1, -1, 0, FrameLen};
    vecs[1] = '{100, 1, 1, 50, 20, FrameLen};
    vecs[2] = '{30, 1, 6, -1, 0, FrameLen};
    foreach (vecs[i]) begin
      gnt_pct = vecs[i].gnt_pct;
      lat_min = vecs[i].lat_min;
      lat_max = vecs[i].lat_max;
      bp_trig = vecs[i].bp_word;
      bp_len  = vecs[i].bp_len;
      start_frame();
      run_frame($sformatf("vec%0d", i), vecs[i].exp_words);
    end

    // Abort deep in a frame with long latency, then restart from word 0.
    gnt_pct = 100; lat_min = 6; lat_max = 6;
    abort_seq("abort", 100, 1'b0);
    start_frame();
    run_frame("restart", FrameLen);

    // start while streaming is ignored; start+abort together aborts.
    lat_min = 1; lat_max = 3;
    start_frame();
    wait_words(30);
    start_nxt = 1'b1;
    run_frame("start_ignored", FrameLen);
    abort_seq("start_abort", 40, 1'b1);

    // Reset mid-frame clears everything immediately.
    start_frame();
    wait_words(60);
    #2 rst = 1'b1;
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    #1 check_idle_outputs("rst_async");
    @(posedge clk_200m);
    #1 check_idle_outputs("rst_edge");
    rq.delete();
    req_prev = 1'b0;
    @(negedge clk_200m);
    rst = 1'b0;

    gnt_pct = 70; lat_min = 1; lat_max = 4;
    start_frame();
    run_frame("after_reset", FrameLen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
